// File: rtl/mod_desplazamiento_izq_seq_pkg.sv
// Shared constants, state encoding and shift-amount saturation helper
// for the sequential left shifter/rotator.
package mod_desplazamiento_izq_seq_pkg;

  localparam int W_DEF = 6;  // default operand/result width
  localparam int NW    = 3;  // shift-amount width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Clamp a requested shift amount to the operand width.
  function automatic logic [NW-1:0] sat_amount(input logic [NW-1:0] n, input int w);
    logic [NW-1:0] r;
    if (int'(n) > w) begin
      r = NW'(w);
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_desplazamiento_izq_seq_if.sv
// Request/result bundle of the sequential shifter. The master drives the
// request (START, A, N, MODE); the slave returns result, flags and status.
interface mod_desplazamiento_izq_seq_if
  import mod_desplazamiento_izq_seq_pkg::*;
#(
  parameter int W = W_DEF
);

  logic          START;
  logic [W-1:0]  A;
  logic [NW-1:0] N;
  logic          MODE;
  logic [W-1:0]  Y;
  logic          C;
  logic          Z;
  logic          BUSY;
  logic          DONE;

  modport master (
    output START, A, N, MODE,
    input  Y, C, Z, BUSY, DONE
  );

  modport slave (
    input  START, A, N, MODE,
    output Y, C, Z, BUSY, DONE
  );

endinterface

// File: rtl/mod_desplazamiento_izq.sv
// One-bit left shift step: the MSB leaves through COUT and FILL enters at
// the LSB. Rotation is obtained by the caller feeding the MSB back as FILL.
module mod_desplazamiento_izq #(
  parameter int W = 6
) (
  input  logic [W-1:0] A,
  input  logic         FILL,
  output logic [W-1:0] Y,
  output logic         COUT
);

  assign Y    = {A[W-2:0], FILL};
  assign COUT = A[W-1];

endmodule

// File: rtl/mod_desplazamiento_izq_seq.sv
// Sequential left shifter/rotator: captures an operand and a shift amount,
// then applies one single-bit step per clock until the count is exhausted.
// Results and flags are registered and only move when the FIN state is entered.
module mod_desplazamiento_izq_seq
  import mod_desplazamiento_izq_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  mod_desplazamiento_izq_seq_if.slave  bus
);

  localparam logic [NW-1:0] CNT_ZERO = {NW{1'b0}};
  localparam logic [NW-1:0] CNT_ONE  = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  WORD_ZERO = {W{1'b0}};

  state_t        state_r, state_s;
  logic [W-1:0]  work_r, work_s;
  logic [NW-1:0] cnt_r, cnt_s;
  logic          mode_r, mode_s;
  logic          carry_r, carry_s;
  logic [W-1:0]  y_r, y_s;
  logic          c_r, c_s;
  logic          z_r, z_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  logic [NW-1:0] n_sat_s;
  logic          fill_s;
  logic [W-1:0]  step_y_s;
  logic          step_cout_s;

  assign n_sat_s = sat_amount(bus.N, W);
  assign fill_s  = mode_r ? work_r[W-1] : 1'b0;

  mod_desplazamiento_izq #(.W(W)) u_step (
    .A    (work_r),
    .FILL (fill_s),
    .Y    (step_y_s),
    .COUT (step_cout_s)
  );

  // Next-state and next-datapath decode; everything holds unless stated.
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    carry_s = carry_r;
    y_s     = y_r;
    c_s     = c_r;
    z_s     = z_r;
    case (state_r)
      IDLE: begin
        if (bus.START) begin
          work_s  = bus.A;
          cnt_s   = n_sat_s;
          mode_s  = bus.MODE;
          carry_s = 1'b0;
          if (n_sat_s != CNT_ZERO) begin
            state_s = SHIFT;
          end else begin
            // Zero-length request: result is the operand itself.
            state_s = FIN;
            y_s     = bus.A;
            c_s     = 1'b0;
            z_s     = (bus.A == WORD_ZERO);
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s  = step_y_s;
        carry_s = step_cout_s;
        cnt_s   = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          // Last step: publish the shifted word and its carry on FIN entry.
          state_s = FIN;
          y_s     = step_y_s;
          c_s     = step_cout_s;
          z_s     = (step_y_s == WORD_ZERO);
        end else begin
          state_s = SHIFT;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == FIN);
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset clears everything, aborting any operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      work_r  <= WORD_ZERO;
      cnt_r   <= CNT_ZERO;
      mode_r  <= 1'b0;
      carry_r <= 1'b0;
      y_r     <= WORD_ZERO;
      c_r     <= 1'b0;
      z_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      work_r  <= work_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      carry_r <= carry_s;
      y_r     <= y_s;
      c_r     <= c_s;
      z_r     <= z_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.Y    = y_r;
  assign bus.C    = c_r;
  assign bus.Z    = z_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;

endmodule

// File: tb/tb_mod_desplazamiento_izq_seq.sv
// Self-checking bench: arithmetic reference model checked every cycle,
// directed cases with hand-computed results, then randomized traffic.
module tb_mod_desplazamiento_izq_seq;
  import mod_desplazamiento_izq_seq_pkg::*;

  localparam int W    = 6;
  localparam int MASK = (1 << W) - 1;

  logic CLK = 1'b0;
  logic RST;

  mod_desplazamiento_izq_seq_if #(.W(W)) bus ();

  mod_desplazamiento_izq_seq #(.W(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model state (what the outputs must read after each edge).
  int m_phase = 0;
  int m_rem   = 0;
  int m_y     = 0;
  bit m_c     = 1'b0;
  bit m_z     = 1'b0;
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;
  int pend_y  = 0;
  bit pend_c  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift/rotate result from plain arithmetic: the last bit out of the MSB
  // after k steps is the original bit W-k.
  function automatic void ref_op(input int a, input int n, input bit mode,
                                 output int y, output bit c);
    int k;
    k = (n > W) ? W : n;
    if (k == 0) begin
      y = a & MASK;
      c = 1'b0;
    end else begin
      c = ((a >> (W - k)) & 1) != 0;
      if (!mode) y = (a << k) & MASK;
      else       y = ((a << k) | (a >> (W - k))) & MASK;
    end
  endfunction

  // Reference model: accept in idle, wait k cycles, show result for one cycle.
  always @(posedge CLK) begin : model
    int nph, nrem, ny, k;
    bit nc, nz, nbusy, ndone;
    nph = m_phase; nrem = m_rem; ny = m_y; nc = m_c; nz = m_z;
    nbusy = m_busy; ndone = m_done;
    if (RST) begin
      nph = 0; nrem = 0; ny = 0; nc = 1'b0; nz = 1'b0; nbusy = 1'b0; ndone = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.START) begin
          ref_op(int'(bus.A), int'(bus.N), bus.MODE, pend_y, pend_c);
          k = (int'(bus.N) > W) ? W : int'(bus.N);
          nrem = k; nbusy = 1'b1; nph = 1;
        end
        1: nrem = m_rem - 1;
        default: begin nph = 0; nbusy = 1'b0; ndone = 1'b0; end
      endcase
      if (nph == 1 && nrem == 0) begin
        ny = pend_y; nc = pend_c; nz = (pend_y == 0); ndone = 1'b1; nph = 2;
      end
    end
    m_phase <= nph; m_rem <= nrem; m_y <= ny; m_c <= nc; m_z <= nz;
    m_busy <= nbusy; m_done <= ndone;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (check_en) begin
      check("Y",    32'(bus.Y),    32'(m_y));
      check("C",    32'(bus.C),    32'(m_c));
      check("Z",    32'(bus.Z),    32'(m_z));
      check("BUSY", 32'(bus.BUSY), 32'(m_busy));
      check("DONE", 32'(bus.DONE), 32'(m_done));
    end
  end

  // One request with literal expectations; inputs are scrambled after capture.
  task automatic do_op(input string tag, input logic [W-1:0] a, input int n, input bit mode,
                       input int ey, input bit ec, input bit ez, input int elat);
    int cycles, busy_cnt;
    bit got;
    bus.START = 1'b0;
    @(negedge CLK);
    bus.START = 1'b1; bus.A = a; bus.N = 3'(n); bus.MODE = mode;
    cycles = 0; busy_cnt = 0; got = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge CLK);
      cycles++;
      bus.START = 1'b0;
      bus.A = W'($urandom); bus.N = 3'($urandom); bus.MODE = 1'($urandom);
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) got = 1'b1;
    end
    check({tag, "_lat"},  32'(got ? cycles : 0), 32'(elat));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(elat));
    check({tag, "_Y"},    32'(bus.Y), 32'(ey));
    check({tag, "_C"},    32'(bus.C), 32'(ec));
    check({tag, "_Z"},    32'(bus.Z), 32'(ez));
  endtask

  initial begin : stim
    int ry;
    bit rc;
    int done_at[$];
    RST = 1'b1;
    bus.START = 1'b0; bus.A = '0; bus.N = '0; bus.MODE = 1'b0;

    // Model pins against hand-computed values.
    ref_op(6'b101101, 2, 1'b0, ry, rc);
    check("model_lsl2_y", 32'(ry), 32'(6'b110100));
    check("model_lsl2_c", 32'(rc), 32'd0);
    ref_op(6'b101101, 3, 1'b1, ry, rc);
    check("model_rol3_y", 32'(ry), 32'(6'b101101));
    check("model_rol3_c", 32'(rc), 32'd1);
    ref_op(6'b111111, 7, 1'b0, ry, rc);
    check("model_sat_y", 32'(ry), 32'd0);
    check("model_sat_c", 32'(rc), 32'd1);

    repeat (2) @(negedge CLK);
    check_en = 1'b1;
    check("rst_Y",    32'(bus.Y),    32'd0);
    check("rst_BUSY", 32'(bus.BUSY), 32'd0);
    check("rst_DONE", 32'(bus.DONE), 32'd0);
    RST = 1'b0;

    do_op("lsl2", 6'b101101, 2, 1'b0, 6'b110100, 1'b0, 1'b0, 3);
    do_op("rol3", 6'b101101, 3, 1'b1, 6'b101101, 1'b1, 1'b0, 4);
    do_op("sat7", 6'b111111, 7, 1'b0, 6'b000000, 1'b1, 1'b1, 7);
    do_op("rol6", 6'b100110, 6, 1'b1, 6'b100110, 1'b0, 1'b0, 7);

    // N=0, START during FIN ignored, START in next IDLE accepted.
    @(negedge CLK);
    bus.START = 1'b1; bus.A = 6'b010101; bus.N = 3'd0; bus.MODE = 1'b0;
    @(negedge CLK);
    check("n0_DONE", 32'(bus.DONE), 32'd1);
    check("n0_Y",    32'(bus.Y),    32'(6'b010101));
    check("n0_C",    32'(bus.C),    32'd0);
    bus.A = 6'b111000; bus.N = 3'd1;
    @(negedge CLK);
    check("fin_ign_BUSY", 32'(bus.BUSY), 32'd0);
    check("fin_ign_Y",    32'(bus.Y),    32'(6'b010101));
    bus.A = 6'b000111; bus.N = 3'd1;
    @(negedge CLK);
    check("idle_acc_BUSY", 32'(bus.BUSY), 32'd1);
    bus.START = 1'b0;
    @(negedge CLK);
    check("idle_acc_DONE", 32'(bus.DONE), 32'd1);
    check("idle_acc_Y",    32'(bus.Y),    32'(6'b001110));

    // Reset in the 2nd SHIFT cycle aborts with cleared outputs.
    @(negedge CLK);
    bus.START = 1'b1; bus.A = 6'b000001; bus.N = 3'd5; bus.MODE = 1'b0;
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_Y",    32'(bus.Y),    32'd0);
    check("abort_C",    32'(bus.C),    32'd0);
    check("abort_Z",    32'(bus.Z),    32'd0);
    check("abort_BUSY", 32'(bus.BUSY), 32'd0);
    check("abort_DONE", 32'(bus.DONE), 32'd0);
    RST = 1'b0;
    do_op("after_abort", 6'b000001, 5, 1'b0, 6'b100000, 1'b0, 1'b0, 6);

    // Randomized traffic, including START while busy and sporadic resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      bus.START = 1'($urandom);
      bus.A     = W'($urandom);
      bus.N     = 3'($urandom);
      bus.MODE  = 1'($urandom);
      RST       = ($urandom_range(0, 49) == 0);
    end

    // START held high: one request per min(N,W)+2 cycles.
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.START = 1'b1; bus.A = 6'b101101; bus.N = 3'd2; bus.MODE = 1'b0;
    for (int i = 0; i < 40 && done_at.size() < 3; i++) begin
      @(negedge CLK);
      if (bus.DONE) done_at.push_back(i);
    end
    if (done_at.size() < 3) begin
      check("b2b_pulses", 32'(done_at.size()), 32'd3);
    end else begin
      check("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'd4);
      check("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'd4);
    end
    bus.START = 1'b0;
    repeat (8) @(negedge CLK);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
